// File: rtl/reward_scheduler_pkg.sv
// Shared definitions for the reward scheduler: grid limits, reward type codes,
// FSM state encoding and the LFSR seed.
package reward_scheduler_pkg;

    localparam int GRID_W = 40;
    localparam int GRID_H = 30;

    typedef logic [5:0] coord_t;
    typedef logic [1:0] reward_t;

    localparam coord_t GRID_X_LIM = 6'(GRID_W);
    localparam coord_t GRID_Y_LIM = 6'(GRID_H);

    localparam reward_t RT_NONE      = 2'b00;
    localparam reward_t RT_PROTECTED = 2'b01;
    localparam reward_t RT_GRADE     = 2'b10;
    localparam reward_t RT_SLOWLY    = 2'b11;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DRAW,
        ST_PROBE,
        ST_CHECK,
        ST_SHOW,
        ST_EFFECT
    } state_t;

    // A raw draw of 00 would mean "no reward", so it is folded onto the protected type.
    function automatic reward_t map_type(input reward_t raw);
        return (raw == RT_NONE) ? RT_PROTECTED : raw;
    endfunction

endpackage

// File: rtl/reward_scheduler_if.sv
// Game-side signal bundle of the reward scheduler; the slave modport is the
// scheduler's view, the master modport the game/testbench view.
interface reward_scheduler_if;
    import reward_scheduler_pkg::*;

    logic    enable_reward;
    logic    game_running;
    coord_t  head_xpos;
    coord_t  head_ypos;
    coord_t  probe_xpos;
    coord_t  probe_ypos;
    logic    probe_occupied;
    logic    set_require;
    coord_t  random_xpos;
    coord_t  random_ypos;
    reward_t reward_type;
    logic    reward_taken;
    logic    effect_active;
    reward_t effect_type;

    modport slave (
        input  enable_reward, game_running, head_xpos, head_ypos, probe_occupied,
        output probe_xpos, probe_ypos, set_require, random_xpos, random_ypos,
               reward_type, reward_taken, effect_active, effect_type
    );

    modport master (
        output enable_reward, game_running, head_xpos, head_ypos, probe_occupied,
        input  probe_xpos, probe_ypos, set_require, random_xpos, random_ypos,
               reward_type, reward_taken, effect_active, effect_type
    );

endinterface

// File: rtl/reward_lfsr.sv
// Free-running 16-bit Fibonacci LFSR, polynomial x^16+x^15+x^13+x^4+1.
// Maximal length from a non-zero seed, so the all-zero state is never reached.
module reward_lfsr
    import reward_scheduler_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] rnd
);

    logic [15:0] r_state;
    logic        w_feedback;

    assign w_feedback = r_state[15] ^ r_state[14] ^ r_state[12] ^ r_state[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= LFSR_SEED;
        else        r_state <= {r_state[14:0], w_feedback};
    end

    assign rnd = r_state;

endmodule

// File: rtl/reward_scheduler.sv
// Places a bonus reward on a free grid cell, times its visibility, detects the
// snake eating it and times the resulting effect.
module reward_scheduler
    import reward_scheduler_pkg::*;
#(
    parameter int TICK_DIV    = 50000,
    parameter int SPAWN_DELAY = 3000,
    parameter int LIFETIME    = 8000,
    parameter int EFFECT_TIME = 5000,
    parameter int MAX_TRIES   = 8
) (
    input logic               clk,
    input logic               rst_n,
    reward_scheduler_if.slave bus
);

    localparam logic [31:0] TICK_LAST   = 32'(TICK_DIV - 1);
    localparam logic [15:0] SPAWN_LOAD  = 16'(SPAWN_DELAY - 1);
    localparam logic [15:0] LIFE_LOAD   = 16'(LIFETIME - 1);
    localparam logic [15:0] EFFECT_LOAD = 16'(EFFECT_TIME - 1);
    localparam logic [7:0]  TRIES_LIMIT = 8'(MAX_TRIES);

    state_t      r_state, w_next;
    logic [31:0] r_presc;
    logic [15:0] r_timer, w_timerN;
    logic [7:0]  r_tries, w_triesN, w_triesInc;
    coord_t      r_candX, r_candY, w_candXN, w_candYN;
    coord_t      r_rewX, r_rewY, w_rewXN, w_rewYN;
    reward_t     r_type, w_typeN, r_effType, w_effTypeN;
    logic        r_set, w_setN, r_taken, w_takenN, r_effActive, w_effActiveN;
    logic [15:0] w_rnd;
    coord_t      w_drawX, w_drawY;
    logic        w_tick, w_timerZero, w_drawOk, w_triesOut, w_hitHead, w_caught;
    logic        w_unused;

    reward_lfsr u_lfsr (.clk(clk), .rst_n(rst_n), .rnd(w_rnd));

    assign w_drawX     = w_rnd[5:0];
    assign w_drawY     = w_rnd[11:6];
    assign w_drawOk    = (w_drawX < GRID_X_LIM) && (w_drawY < GRID_Y_LIM);
    assign w_tick      = bus.game_running && (r_presc == TICK_LAST);
    assign w_timerZero = (r_timer == 16'd0);
    assign w_triesInc  = r_tries + 8'd1;
    assign w_triesOut  = (w_triesInc >= TRIES_LIMIT);
    assign w_hitHead   = (r_candX == bus.head_xpos) && (r_candY == bus.head_ypos);
    assign w_caught    = (r_rewX == bus.head_xpos) && (r_rewY == bus.head_ypos);
    assign w_unused    = ^w_rnd[15:14];

    // Prescaler only runs in play, which is what freezes every timer during a pause.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  r_presc <= '0;
        else if (!bus.enable_reward) r_presc <= '0;
        else if (bus.game_running)   r_presc <= (r_presc == TICK_LAST) ? '0 : r_presc + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_timer     <= '0;
            r_tries     <= '0;
            r_candX     <= '0;
            r_candY     <= '0;
            r_rewX      <= '0;
            r_rewY      <= '0;
            r_type      <= RT_NONE;
            r_set       <= 1'b0;
            r_taken     <= 1'b0;
            r_effActive <= 1'b0;
            r_effType   <= RT_NONE;
        end else begin
            r_state     <= w_next;
            r_timer     <= w_timerN;
            r_tries     <= w_triesN;
            r_candX     <= w_candXN;
            r_candY     <= w_candYN;
            r_rewX      <= w_rewXN;
            r_rewY      <= w_rewYN;
            r_type      <= w_typeN;
            r_set       <= w_setN;
            r_taken     <= w_takenN;
            r_effActive <= w_effActiveN;
            r_effType   <= w_effTypeN;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_timerN     = r_timer;
        w_triesN     = r_tries;
        w_candXN     = r_candX;
        w_candYN     = r_candY;
        w_rewXN      = r_rewX;
        w_rewYN      = r_rewY;
        w_typeN      = r_type;
        w_setN       = r_set;
        w_takenN     = 1'b0;
        w_effActiveN = r_effActive;
        w_effTypeN   = r_effType;

        case (r_state)
            ST_IDLE: begin
                w_next   = ST_WAIT;
                w_timerN = SPAWN_LOAD;
            end
            ST_WAIT: begin
                if (w_tick) begin
                    if (w_timerZero) begin
                        w_next   = ST_DRAW;
                        w_triesN = '0;
                    end else begin
                        w_timerN = r_timer - 16'd1;
                    end
                end
            end
            ST_DRAW: begin
                if (w_drawOk) begin
                    w_candXN = w_drawX;
                    w_candYN = w_drawY;
                    w_next   = ST_PROBE;
                end else if (w_triesOut) begin
                    w_next   = ST_WAIT;
                    w_timerN = SPAWN_LOAD;
                end else begin
                    w_triesN = w_triesInc;
                end
            end
            ST_PROBE: w_next = ST_CHECK;
            ST_CHECK: begin
                if (!bus.probe_occupied && !w_hitHead) begin
                    w_rewXN  = r_candX;
                    w_rewYN  = r_candY;
                    w_typeN  = map_type(w_rnd[13:12]);
                    w_setN   = 1'b1;
                    w_timerN = LIFE_LOAD;
                    w_next   = ST_SHOW;
                end else if (w_triesOut) begin
                    w_next   = ST_WAIT;
                    w_timerN = SPAWN_LOAD;
                end else begin
                    w_triesN = w_triesInc;
                    w_next   = ST_DRAW;
                end
            end
            // Catch is tested before expiry so a bite on the last tick still counts.
            ST_SHOW: begin
                if (w_caught) begin
                    w_takenN     = 1'b1;
                    w_setN       = 1'b0;
                    w_typeN      = RT_NONE;
                    w_effActiveN = 1'b1;
                    w_effTypeN   = r_type;
                    w_timerN     = EFFECT_LOAD;
                    w_next       = ST_EFFECT;
                end else if (w_tick) begin
                    if (w_timerZero) begin
                        w_setN   = 1'b0;
                        w_typeN  = RT_NONE;
                        w_timerN = SPAWN_LOAD;
                        w_next   = ST_WAIT;
                    end else begin
                        w_timerN = r_timer - 16'd1;
                    end
                end
            end
            ST_EFFECT: begin
                if (w_tick) begin
                    if (w_timerZero) begin
                        w_effActiveN = 1'b0;
                        w_effTypeN   = RT_NONE;
                        w_timerN     = SPAWN_LOAD;
                        w_next       = ST_WAIT;
                    end else begin
                        w_timerN = r_timer - 16'd1;
                    end
                end
            end
            default: w_next = ST_IDLE;
        endcase

        if (!bus.enable_reward) begin
            w_next       = ST_IDLE;
            w_timerN     = '0;
            w_triesN     = '0;
            w_candXN     = '0;
            w_candYN     = '0;
            w_rewXN      = '0;
            w_rewYN      = '0;
            w_typeN      = RT_NONE;
            w_setN       = 1'b0;
            w_takenN     = 1'b0;
            w_effActiveN = 1'b0;
            w_effTypeN   = RT_NONE;
        end
    end

    assign bus.probe_xpos    = r_candX;
    assign bus.probe_ypos    = r_candY;
    assign bus.set_require   = r_set;
    assign bus.random_xpos   = r_rewX;
    assign bus.random_ypos   = r_rewY;
    assign bus.reward_type   = r_type;
    assign bus.reward_taken  = r_taken;
    assign bus.effect_active = r_effActive;
    assign bus.effect_type   = r_effType;

endmodule

// File: tb/tb_reward_scheduler.sv
// Scoreboard bench: stimulus queues the expected placements, show windows and
// effect windows; a negedge monitor pops and checks them as the outputs move.
module tb_reward_scheduler;
    import reward_scheduler_pkg::*;

    localparam int OCC_NONE = 0;
    localparam int OCC_ALL  = 1;
    localparam int OCC_LEFT = 2;

    typedef struct {
        int   len;
        logic caught;
    } showExp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   occMode = OCC_NONE;
    int   checks = 0;
    int   errors = 0;

    int       placeQ[$];
    showExp_t showQ[$];
    int       effQ[$];

    int      monSetLen = 0;
    int      monEffLen = 0;
    int      monTakenLen = 0;
    logic    monPrevSet = 1'b0;
    logic    monPrevEff = 1'b0;
    logic    monPrevTaken = 1'b0;
    reward_t monLastType = RT_NONE;

    reward_scheduler_if bus ();

    reward_scheduler #(
        .TICK_DIV(1), .SPAWN_DELAY(4), .LIFETIME(10), .EFFECT_TIME(6), .MAX_TRIES(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Occupancy lookup answers one cycle after the probe; OCC_LEFT marks columns 0..19 as snake body.
    always @(posedge clk) begin
        case (occMode)
            OCC_ALL:  bus.probe_occupied <= 1'b1;
            OCC_LEFT: bus.probe_occupied <= (bus.probe_xpos < 6'd20);
            default:  bus.probe_occupied <= 1'b0;
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic run, input coord_t hx, input coord_t hy);
        bus.enable_reward = en;
        bus.game_running  = run;
        bus.head_xpos     = hx;
        bus.head_ypos     = hy;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_set_require"}, bus.set_require, 0);
        checkOutput({tag, "_reward_type"}, bus.reward_type, 0);
        checkOutput({tag, "_reward_taken"}, bus.reward_taken, 0);
        checkOutput({tag, "_effect_active"}, bus.effect_active, 0);
        checkOutput({tag, "_effect_type"}, bus.effect_type, 0);
        checkOutput({tag, "_random_xpos"}, bus.random_xpos, 0);
        checkOutput({tag, "_random_ypos"}, bus.random_ypos, 0);
    endtask

    task automatic expectShow(input int len, input logic caught);
        showExp_t s;
        s.len = len;
        s.caught = caught;
        showQ.push_back(s);
    endtask

    task automatic waitRise(input int budget, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.set_require && lat < budget);
        if (!bus.set_require) checkOutput("placement_timeout", 0, 1);
    endtask

    task automatic waitFall(input int budget);
        int n = 0;
        while (bus.set_require && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (bus.set_require) checkOutput("show_end_timeout", 0, 1);
    endtask

    task automatic waitEffectEnd(input int budget);
        int n = 0;
        while (bus.effect_active && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (bus.effect_active) checkOutput("effect_end_timeout", 0, 1);
    endtask

    always @(negedge clk) begin : monitor
        showExp_t s;
        int       minX;
        if (bus.set_require && !monPrevSet) begin
            checkOutput("place_expected", placeQ.size() > 0, 1);
            if (placeQ.size() > 0) begin
                minX = placeQ.pop_front();
                checkOutput("place_x_in_range", (int'(bus.random_xpos) >= minX) && (bus.random_xpos < 6'd40), 1);
                checkOutput("place_y_in_range", bus.random_ypos < 6'd30, 1);
                checkOutput("place_type_nonzero", bus.reward_type != RT_NONE, 1);
                checkOutput("place_no_effect", bus.effect_active, 0);
            end
            monLastType = bus.reward_type;
        end
        if (bus.set_require) monSetLen++;
        else if (monPrevSet) begin
            checkOutput("show_end_expected", showQ.size() > 0, 1);
            if (showQ.size() > 0) begin
                s = showQ.pop_front();
                checkOutput("show_length", monSetLen, s.len);
                checkOutput("show_end_taken", bus.reward_taken, s.caught);
                checkOutput("show_end_type_cleared", bus.reward_type, 0);
            end
            monSetLen = 0;
        end

        if (bus.effect_active && !monPrevEff)
            checkOutput("effect_type_matches_reward", bus.effect_type, monLastType);
        if (bus.effect_active) monEffLen++;
        else if (monPrevEff) begin
            checkOutput("effect_end_expected", effQ.size() > 0, 1);
            if (effQ.size() > 0) checkOutput("effect_length", monEffLen, effQ.pop_front());
            checkOutput("effect_type_cleared", bus.effect_type, 0);
            monEffLen = 0;
        end

        if (bus.reward_taken) monTakenLen++;
        else if (monPrevTaken) begin
            checkOutput("taken_pulse_width", monTakenLen, 1);
            monTakenLen = 0;
        end

        monPrevSet   = bus.set_require;
        monPrevEff   = bus.effect_active;
        monPrevTaken = bus.reward_taken;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: time limit reached, %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b1, 6'd63, 6'd63);
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkIdle("reset");
        checkOutput("lfsr_seed", dut.u_lfsr.rnd, 16'hACE1);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("lfsr_first_step", dut.u_lfsr.rnd, 16'h59C3);

        $display("[TB] expiry without catch, left half occupied");
        for (int i = 0; i < 3; i++) begin
            occMode = OCC_LEFT;
            placeQ.push_back(20);
            expectShow(10, 1'b0);
            bus.enable_reward = 1'b1;
            waitRise(2000, lat);
            checkOutput("spawn_latency_min", lat >= 8, 1);
            waitFall(100);
            bus.enable_reward = 1'b0;
            @(negedge clk);
            checkIdle("disable_in_wait");
        end

        $display("[TB] catch on third show cycle, then respawn");
        occMode = OCC_NONE;
        placeQ.push_back(0);
        expectShow(3, 1'b1);
        effQ.push_back(6);
        placeQ.push_back(0);
        expectShow(3, 1'b0);
        bus.enable_reward = 1'b1;
        waitRise(2000, lat);
        repeat (2) @(negedge clk);
        applyStimulus(1'b1, 1'b1, bus.random_xpos, bus.random_ypos);
        @(negedge clk);
        checkOutput("catch_pulse", bus.reward_taken, 1);
        checkOutput("catch_clears_set", bus.set_require, 0);
        checkOutput("catch_sets_effect", bus.effect_active, 1);
        applyStimulus(1'b1, 1'b1, 6'd63, 6'd63);
        waitEffectEnd(100);
        waitRise(2000, lat);
        repeat (2) @(negedge clk);
        bus.enable_reward = 1'b0;
        @(negedge clk);
        checkIdle("disable_in_show");

        $display("[TB] catch in the expiry cycle");
        placeQ.push_back(0);
        expectShow(10, 1'b1);
        effQ.push_back(6);
        bus.enable_reward = 1'b1;
        waitRise(2000, lat);
        repeat (9) @(negedge clk);
        applyStimulus(1'b1, 1'b1, bus.random_xpos, bus.random_ypos);
        @(negedge clk);
        checkOutput("expiry_catch_pulse", bus.reward_taken, 1);
        checkOutput("expiry_catch_effect", bus.effect_active, 1);
        applyStimulus(1'b1, 1'b1, 6'd63, 6'd63);
        waitEffectEnd(100);
        bus.enable_reward = 1'b0;
        @(negedge clk);
        checkIdle("disable_after_effect");

        $display("[TB] every probe occupied, then free, then pause mid-show");
        occMode = OCC_ALL;
        bus.enable_reward = 1'b1;
        repeat (300) @(negedge clk);
        checkOutput("occupied_never_places", bus.set_require, 0);
        placeQ.push_back(0);
        expectShow(30, 1'b0);
        occMode = OCC_NONE;
        waitRise(2000, lat);
        repeat (3) @(negedge clk);
        bus.game_running = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("paused_still_visible", bus.set_require, 1);
        bus.game_running = 1'b1;
        waitFall(100);
        bus.enable_reward = 1'b0;
        @(negedge clk);
        checkIdle("disable_after_pause");

        $display("[TB] disable during effect");
        placeQ.push_back(0);
        expectShow(3, 1'b1);
        effQ.push_back(2);
        bus.enable_reward = 1'b1;
        waitRise(2000, lat);
        repeat (2) @(negedge clk);
        applyStimulus(1'b1, 1'b1, bus.random_xpos, bus.random_ypos);
        @(negedge clk);
        checkOutput("effect_catch_pulse", bus.reward_taken, 1);
        applyStimulus(1'b1, 1'b1, 6'd63, 6'd63);
        @(negedge clk);
        bus.enable_reward = 1'b0;
        @(negedge clk);
        checkIdle("disable_in_effect");

        $display("[TB] asynchronous reset during show");
        placeQ.push_back(0);
        expectShow(4, 1'b0);
        bus.enable_reward = 1'b1;
        waitRise(2000, lat);
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b0;
        bus.enable_reward = 1'b0;
        #1;
        checkIdle("async_reset");
        checkOutput("async_reset_lfsr_seed", dut.u_lfsr.rnd, 16'hACE1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("lfsr_restart_step", dut.u_lfsr.rnd, 16'h59C3);

        repeat (5) @(negedge clk);
        checkOutput("placeQ_drained", placeQ.size(), 0);
        checkOutput("showQ_drained", showQ.size(), 0);
        checkOutput("effQ_drained", effQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
